// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW burst sequencer: state encoding and default widths.
package qcw_pkg;

  // Default width of period / phase-shift quantities (oscillator counter units).
  localparam int QCW_W  = 24;
  // Default width of the burst cycle counter.
  localparam int QCW_CW = 16;

  // State encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STOP = 3'd3;
  localparam logic [2:0] ST_COOL = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN,
    S_STOP = ST_STOP,
    S_COOL = ST_COOL
  } qcw_state_e;

endpackage

// File: rtl/qcw_phase_ramp.sv
// Phase-shift register with a saturating step adder. init loads the starting
// phase; advance adds one step and clamps at the end phase. The sum is taken
// one bit wider than the operands so a large step can never wrap past pe.
module qcw_phase_ramp #(
  parameter int W = qcw_pkg::QCW_W
) (
  input  logic         clk_logic,
  input  logic         reset,
  input  logic         init_i,
  input  logic         advance_i,
  input  logic [W-1:0] ps_i,
  input  logic [W-1:0] pe_i,
  input  logic [W-1:0] step_i,
  output logic [W-1:0] phase_o
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;
  logic [W:0]   sum;

  // Next phase: init has priority, otherwise saturating advance toward pe.
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, step_i};
    phase_d = phase_q;
    if (init_i) begin
      phase_d = ps_i;
    end else if (advance_i) begin
      phase_d = (sum >= {1'b0, pe_i}) ? pe_i : sum[W-1:0];
    end
  end

  // Phase register.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/qcw_ramp_ctrl.sv
// QCW burst sequencer. Latches a burst configuration on trigger, loads and
// enables the phase-shifted bridge oscillator, ramps the phase shift once per
// oscillator cycle, then stops the oscillator, waits out a cooldown and
// reports completion. Abort or a missing final cycle boundary sets aborted.
module qcw_ramp_ctrl #(
  parameter int W          = qcw_pkg::QCW_W,
  parameter int CW         = qcw_pkg::QCW_CW,
  parameter int STOP_SLACK = 4
) (
  input  logic          clk_logic,
  input  logic          reset,
  input  logic          trigger,
  input  logic          abort,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_phase_start,
  input  logic [W-1:0]  cfg_phase_end,
  input  logic [W-1:0]  cfg_phase_step,
  input  logic [CW-1:0] cfg_burst_cycles,
  input  logic [W-1:0]  cfg_cooldown,
  input  logic          osc_cycle_done,
  output logic [W-1:0]  osc_period,
  output logic [W-1:0]  osc_phase_shift,
  output logic          osc_load,
  output logic          osc_enable,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  import qcw_pkg::*;

  qcw_state_e    state_q,      state_d;
  logic [W-1:0]  period_q,     period_d;
  logic [W-1:0]  pe_q,         pe_d;
  logic [W-1:0]  step_q,       step_d;
  logic [CW-1:0] burst_q,      burst_d;
  logic [W-1:0]  cooldown_q,   cooldown_d;
  logic [CW-1:0] cyc_cnt_q,    cyc_cnt_d;
  logic [W-1:0]  stop_cnt_q,   stop_cnt_d;
  logic [W-1:0]  cool_cnt_q,   cool_cnt_d;
  logic          osc_load_q,   osc_load_d;
  logic          osc_enable_q, osc_enable_d;
  logic          aborted_q,    aborted_d;

  logic [W-1:0]  period_half;
  logic [W-1:0]  pe_clamp;
  logic [W-1:0]  ps_clamp;
  logic [W-1:0]  stop_limit;
  logic [CW-1:0] cyc_inc;
  logic          ramp_init;
  logic          ramp_advance;
  logic [W-1:0]  phase;

  // Configuration clamps applied at latch time: the end phase may not exceed
  // half a period, and the start phase may not exceed the end phase.
  always_comb begin
    period_half = cfg_period >> 1;
    pe_clamp    = (cfg_phase_end < period_half) ? cfg_phase_end : period_half;
    ps_clamp    = (cfg_phase_start < pe_clamp) ? cfg_phase_start : pe_clamp;
  end

  // Stop timeout in clk_logic cycles: one oscillator period (8 counter units
  // per clk_logic cycle) plus slack.
  assign stop_limit = (period_q >> 3) + W'(STOP_SLACK);
  assign cyc_inc    = cyc_cnt_q + 1'b1;

  // Next-state logic and registered-output decisions for the burst FSM.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    pe_d         = pe_q;
    step_d       = step_q;
    burst_d      = burst_q;
    cooldown_d   = cooldown_q;
    cyc_cnt_d    = cyc_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    cool_cnt_d   = cool_cnt_q;
    osc_load_d   = 1'b0;
    osc_enable_d = osc_enable_q;
    aborted_d    = aborted_q;
    ramp_init    = 1'b0;
    ramp_advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger && (cfg_burst_cycles != '0)) begin
          period_d     = cfg_period;
          pe_d         = pe_clamp;
          step_d       = cfg_phase_step;
          burst_d      = cfg_burst_cycles;
          cooldown_d   = cfg_cooldown;
          cyc_cnt_d    = '0;
          aborted_d    = 1'b0;
          ramp_init    = 1'b1;
          // Load and enable rise together on the LOAD cycle.
          osc_load_d   = 1'b1;
          osc_enable_d = 1'b1;
          state_d      = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          osc_enable_d = 1'b0;
          aborted_d    = 1'b1;
          stop_cnt_d   = '0;
          state_d      = S_STOP;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Abort wins over a coincident cycle boundary: no phase update.
        if (abort) begin
          osc_enable_d = 1'b0;
          aborted_d    = 1'b1;
          stop_cnt_d   = '0;
          state_d      = S_STOP;
        end else if (osc_cycle_done) begin
          cyc_cnt_d = cyc_inc;
          if (cyc_inc == burst_q) begin
            osc_enable_d = 1'b0;
            stop_cnt_d   = '0;
            state_d      = S_STOP;
          end else begin
            ramp_advance = 1'b1;
            osc_load_d   = 1'b1;
          end
        end
      end

      S_STOP: begin
        // Wait for the oscillator to finish its current period, but never
        // longer than one period plus slack.
        if (osc_cycle_done || (stop_cnt_q >= stop_limit - 1'b1)) begin
          if (!osc_cycle_done) begin
            aborted_d = 1'b1;
          end
          cool_cnt_d = cooldown_q;
          state_d    = S_COOL;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end

      S_COOL: begin
        if (cool_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      pe_q         <= '0;
      step_q       <= '0;
      burst_q      <= '0;
      cooldown_q   <= '0;
      cyc_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      cool_cnt_q   <= '0;
      osc_load_q   <= 1'b0;
      osc_enable_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      pe_q         <= pe_d;
      step_q       <= step_d;
      burst_q      <= burst_d;
      cooldown_q   <= cooldown_d;
      cyc_cnt_q    <= cyc_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      cool_cnt_q   <= cool_cnt_d;
      osc_load_q   <= osc_load_d;
      osc_enable_q <= osc_enable_d;
      aborted_q    <= aborted_d;
    end
  end

  qcw_phase_ramp #(
    .W (W)
  ) u_phase_ramp (
    .clk_logic (clk_logic),
    .reset     (reset),
    .init_i    (ramp_init),
    .advance_i (ramp_advance),
    .ps_i      (ps_clamp),
    .pe_i      (pe_q),
    .step_i    (step_q),
    .phase_o   (phase)
  );

  assign osc_period      = period_q;
  assign osc_phase_shift = phase;
  assign osc_load        = osc_load_q;
  assign osc_enable      = osc_enable_q;
  assign aborted         = aborted_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_COOL) && (cool_cnt_q == '0);

endmodule

// File: doc/qcw_ramp_ctrl.md
Name: qcw_ramp_ctrl

Overview:
- Sequences one QCW burst on the phase-shifted full-bridge oscillator.
- On a trigger it latches the burst configuration, loads period and starting phase shift into the oscillator, and enables it.
- On every oscillator cycle boundary (cycle_done) it advances the phase shift linearly toward a target, so drive power ramps up.
- After N oscillator cycles, or on abort, it stops the oscillator cleanly, enforces a cooldown, and reports completion.
- Sits between the register/command layer and the oscillator in the clk_logic domain.

Parameters:
- W, 24, width of period and phase-shift quantities (oscillator counter units, 8 per clk_logic cycle).
- CW, 16, width of burst cycle counter.
- STOP_SLACK, 4, extra clk_logic cycles added to the stop timeout.

Ports:
- clk_logic  in  1  logic clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- trigger  in  1  start request; level-sampled in IDLE only.
- abort  in  1  stop request; sampled in LOAD and RUN.
- cfg_period  in  W  oscillator period.
- cfg_phase_start  in  W  initial phase shift.
- cfg_phase_end  in  W  final phase shift.
- cfg_phase_step  in  W  per-cycle phase increment.
- cfg_burst_cycles  in  CW  burst length in oscillator cycles; 0 means trigger is ignored.
- cfg_cooldown  in  W  minimum off-time in clk_logic cycles.
- osc_cycle_done  in  1  oscillator cycle-boundary pulse.
- osc_period  out  W  period driven to the oscillator.
- osc_phase_shift  out  W  phase shift driven to the oscillator.
- osc_load  out  1  one-cycle load strobe.
- osc_enable  out  1  oscillator enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of cooldown.
- aborted  out  1  sticky flag; set by abort or stop timeout, cleared on the next accepted trigger.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, LOAD, RUN, STOP, COOL.

IDLE:
- When trigger=1 and cfg_burst_cycles!=0: latch all cfg_* inputs; drive osc_period=cfg_period; go to LOAD.
- Phase clamps at latch:
  - pe = min(cfg_phase_end, cfg_period>>1).
  - ps = min(cfg_phase_start, pe).
- osc_phase_shift=ps; aborted cleared.
- cfg_* changes while not in IDLE have no effect.

LOAD (exactly 1 cycle):
- osc_load=1 and osc_enable=1, both registered, asserted on the cycle after the IDLE decision; go to RUN.

RUN:
- osc_enable held 1.
- On osc_cycle_done, cyc_cnt increments.
  - If the new count == burst_cycles: osc_enable=0 next cycle; go to STOP.
  - Otherwise update the phase and pulse osc_load for 1 cycle on the next cycle.
- Phase update, computed W+1 bits wide: nxt = phase + step; phase <= (nxt >= pe) ? pe : nxt. This saturates, with no wrap.
- step=0 gives a constant phase.
- osc_phase_shift and osc_period change only in the same cycle as osc_load.
- abort=1 in LOAD or RUN:
  - osc_enable=0 next cycle, aborted=1, go to STOP.
  - Any update that coincides with a same-cycle osc_cycle_done is discarded; abort wins.

STOP:
- Wait for one osc_cycle_done; the oscillator finishes its current period and then idles.
- Timeout: if none arrives within (period>>3)+STOP_SLACK clk_logic cycles, set aborted=1 and proceed anyway.
- Go to COOL; load cool_cnt=cooldown.

COOL:
- cool_cnt decrements each cycle. When it reaches 0: done=1 for 1 cycle, go to IDLE.
- cooldown=0: done is asserted on the first COOL cycle.
- trigger is ignored in STOP and COOL; it is not queued.

Other rules:
- osc_load is never asserted while osc_enable=0, except the LOAD cycle, where both rise together.
- reset mid-burst: next cycle all outputs are 0 and the state is IDLE; no done pulse.
- busy=1 from the LOAD cycle through the last COOL cycle inclusive.

Decomposition:
- Shared package qcw_pkg holds:
  - State encoding localparams: ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_STOP=3, ST_COOL=4.
  - The default widths W=24 and CW=16.
- One natural sub-module, qcw_phase_ramp: holds the phase register and the clamped, saturating step adder.
  - Inputs: init/advance strobes, ps/pe/step.
  - Output: current phase.
- The FSM, counters and timeout live in the top module.

Test Plan:
- Basic burst: period=800, ps=0, pe=400, step=100, burst=6, cooldown=10, osc_cycle_done every 100 clk.
  - Required: osc_phase_shift sequence 0,100,200,300,400,400.
  - osc_load pulses: 1 in LOAD plus 5 in RUN.
  - osc_enable falls 1 cycle after the 6th cycle_done.
  - done pulses exactly 10 cycles after STOP exits.
  - aborted=0.
- Clamping: pe=1000 with period=800 gives an effective pe of 400. ps=500 gives a starting phase of 400; all loads then carry 400.
- Abort: assert abort for 1 cycle during RUN cycle 3.
  - Required: osc_enable=0 next cycle, no further osc_load, aborted=1.
  - done is still pulsed after cooldown.
- Stop timeout: never return cycle_done in STOP with period=800.
  - Required: COOL is entered 104 cycles after STOP entry; aborted=1.
- Ignored triggers:
  - trigger with burst=0: stays IDLE, busy=0.
  - trigger held high through COOL: the next burst starts only from IDLE, 1 cycle after done.
- Reset mid-RUN: the cycle after reset, osc_enable=0, osc_load=0, busy=0, and no done pulse.
